spu_mamem_arb: RTL and testbench

Single-port arbiter for the SPU modular-arithmetic scratch memory (mamem). It shares the one read/write port between four requesters: the mul-reduce engine (mared), the exponent sequencer's E-operand reads (maexp), load-op fills from L2 (ldop) and store-op drains to L2 (stop). It grants at most one access per cycle and holds ownership for multi-beat operations. It also inserts a write-to-read turnaround bubble, which removes the idct read/write contention seen when an aborted op overlapped a new ld/st op.

---
 rtl/spu_mamem_arb.sv | 164 ++++++++++++++++
 tb/tb_spu_mamem_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_mamem_arb.sv
// spu_mamem_arb: arbiter sharing the single mamem read/write port between
// mared, maexp, ldop and stop, with multi-beat locking and a write-to-read
// turnaround bubble.
// Build option SPU_MAMEM_ARB_RR_EN: ldop and stop alternate via a 1-bit
// round-robin pointer; when undefined, ldop has fixed priority over stop.
module spu_mamem_arb (
    input  logic       rclk,
    input  logic       reset,
    input  logic       se,
    input  logic       spu_mared_mem_req,
    input  logic       spu_mared_mem_wr,
    input  logic       spu_mared_lock,
    input  logic       spu_maexp_mem_req,
    input  logic       spu_ldop_mem_req,
    input  logic       spu_ldop_lock,
    input  logic       spu_stop_mem_req,
    input  logic       spu_stop_lock,
    input  logic       spu_mactl_kill_op,
    input  logic       spu_mactl_stxa_force_abort,
    output logic [3:0] spu_mamem_gnt,
    output logic       spu_mamem_rd_en,
    output logic       spu_mamem_wr_en,
    output logic [1:0] spu_mamem_owner,
    output logic       spu_mamem_lock_vld,
    output logic       spu_mamem_conflict
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [1:0] ID_MARED = 2'd0;
    localparam logic [1:0] ID_MAEXP = 2'd1;
    localparam logic [1:0] ID_LDOP  = 2'd2;
    localparam logic [1:0] ID_STOP  = 2'd3;

    state_t     state;
    state_t     state_d;
    logic [1:0] owner_d;
    logic [1:0] win_idx;
    logic [1:0] gnt_idx;
    logic [1:0] last_writer;
    logic       win_vld;
    logic       win_wr;
    logic       last_wr;
    logic       cyc_wr;
    logic       abort;
    logic       bubble;
    logic [3:0] req;
    logic [3:0] lock_req;
    logic [3:0] wr_req;
    logic [3:0] gnt;
    logic       scan_unused;

`ifdef SPU_MAMEM_ARB_RR_EN
    logic       rr_ptr;
`endif

    // Requester vectors indexed {stop, ldop, maexp, mared}.
    assign req      = {spu_stop_mem_req, spu_ldop_mem_req, spu_maexp_mem_req, spu_mared_mem_req};
    assign lock_req = {spu_stop_lock, spu_ldop_lock, 1'b0, spu_mared_lock};
    assign wr_req   = {1'b0, 1'b1, 1'b0, spu_mared_mem_wr};
    assign abort    = spu_mactl_kill_op | spu_mactl_stxa_force_abort;

    // No scan chain is modelled inside this block.
    assign scan_unused = se;

    // Fixed-priority winner selection: mared > maexp > ldop/stop.
    always_comb begin
        win_vld = 1'b1;
        win_idx = ID_MARED;
        if (req[ID_MARED])
            win_idx = ID_MARED;
        else if (req[ID_MAEXP])
            win_idx = ID_MAEXP;
`ifdef SPU_MAMEM_ARB_RR_EN
        else if (req[ID_LDOP] && req[ID_STOP])
            win_idx = rr_ptr ? ID_STOP : ID_LDOP;
`endif
        else if (req[ID_LDOP])
            win_idx = ID_LDOP;
        else if (req[ID_STOP])
            win_idx = ID_STOP;
        else
            win_vld = 1'b0;
    end

    assign win_wr = wr_req[win_idx];
    assign bubble = last_wr && (win_idx != last_writer) && !win_wr;

    // Next-state and grant decode; aborts and reset suppress all grants.
    always_comb begin
        gnt     = 4'b0000;
        state_d = state;
        owner_d = spu_mamem_owner;
        if (reset || abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                LOCK: begin
                    if (req[spu_mamem_owner])
                        gnt[spu_mamem_owner] = 1'b1;
                    if (!lock_req[spu_mamem_owner])
                        state_d = (req[spu_mamem_owner] && wr_req[spu_mamem_owner]) ? TURN : IDLE;
                end
                default: begin
                    // IDLE and TURN both re-arbitrate; a read by a different
                    // requester right after a write costs one empty cycle.
                    state_d = IDLE;
                    if (win_vld && !bubble) begin
                        gnt[win_idx] = 1'b1;
                        if (lock_req[win_idx]) begin
                            state_d = LOCK;
                            owner_d = win_idx;
                        end else if (win_wr) begin
                            state_d = TURN;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt_idx         = (state == LOCK) ? spu_mamem_owner : win_idx;
    assign cyc_wr          = |(gnt & wr_req);
    assign spu_mamem_gnt   = gnt;
    assign spu_mamem_wr_en = cyc_wr;
    assign spu_mamem_rd_en = (|gnt) & ~cyc_wr;

    // State, ownership, conflict and last-write tracking registers.
    always_ff @(posedge rclk) begin
        if (reset) begin
            state              <= IDLE;
            spu_mamem_owner    <= ID_MARED;
            spu_mamem_lock_vld <= 1'b0;
            spu_mamem_conflict <= 1'b0;
            last_wr            <= 1'b0;
            last_writer        <= ID_MARED;
        end else begin
            state              <= state_d;
            spu_mamem_owner    <= owner_d;
            spu_mamem_lock_vld <= (state_d == LOCK);
            spu_mamem_conflict <= |(req & ~gnt);
            last_wr            <= cyc_wr;
            if (cyc_wr)
                last_writer <= gnt_idx;
        end
    end

`ifdef SPU_MAMEM_ARB_RR_EN
    // Round-robin pointer points away from whichever of ldop/stop was last served.
    always_ff @(posedge rclk) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (gnt[ID_LDOP])
            rr_ptr <= 1'b1;
        else if (gnt[ID_STOP])
            rr_ptr <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_spu_mamem_arb.sv
// tb_spu_mamem_arb: self-checking bench for spu_mamem_arb.
// Stimulus word: {reset, mared req/wr/lock, maexp req, ldop req/lock, stop req/lock, kill, stxa}.
// Output word:   {gnt[3:0], rd_en, wr_en, owner[1:0], lock_vld, conflict}.
module tb_spu_mamem_arb;

    logic       rclk;
    logic       reset;
    logic       se;
    logic       mared_req, mared_wr, mared_lock, maexp_req;
    logic       ldop_req, ldop_lock, stop_req, stop_lock;
    logic       kill_op, stxa_abort;
    logic [3:0] gnt;
    logic       rd_en, wr_en, lock_vld, conflict;
    logic [1:0] owner;
    logic [9:0] outs;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q [$];

    spu_mamem_arb dut (
        .rclk                       (rclk),
        .reset                      (reset),
        .se                         (se),
        .spu_mared_mem_req          (mared_req),
        .spu_mared_mem_wr           (mared_wr),
        .spu_mared_lock             (mared_lock),
        .spu_maexp_mem_req          (maexp_req),
        .spu_ldop_mem_req           (ldop_req),
        .spu_ldop_lock              (ldop_lock),
        .spu_stop_mem_req           (stop_req),
        .spu_stop_lock              (stop_lock),
        .spu_mactl_kill_op          (kill_op),
        .spu_mactl_stxa_force_abort (stxa_abort),
        .spu_mamem_gnt              (gnt),
        .spu_mamem_rd_en            (rd_en),
        .spu_mamem_wr_en            (wr_en),
        .spu_mamem_owner            (owner),
        .spu_mamem_lock_vld         (lock_vld),
        .spu_mamem_conflict         (conflict)
    );

    assign outs = {gnt, rd_en, wr_en, owner, lock_vld, conflict};

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic apply(input logic [10:0] v);
        reset      = v[10];
        mared_req  = v[9];
        mared_wr   = v[8];
        mared_lock = v[7];
        maexp_req  = v[6];
        ldop_req   = v[5];
        ldop_lock  = v[4];
        stop_req   = v[3];
        stop_lock  = v[2];
        kill_op    = v[1];
        stxa_abort = v[0];
    endtask

    task automatic idle_cycle();
        @(posedge rclk); #1;
        apply(11'd0);
    endtask

    task automatic do_reset();
        @(posedge rclk); #1;
        apply(11'b1_000_0_00_00_00);
        @(posedge rclk);
        @(posedge rclk); #1;
        apply(11'd0);
    endtask

    task automatic test_reset();
        logic [10:0] stim [0:2];
        logic [9:0]  expv [0:2];
        logic [9:0]  e;
        stim = '{11'b1_100_0_00_00_00, 11'b1_000_0_11_00_00, 11'b0_000_0_00_00_00};
        expv = '{10'b0000_0_0_00_0_0, 10'b0000_0_0_00_0_0, 10'b0000_0_0_00_0_0};
        for (int i = 0; i < 3; i++) begin
            @(posedge rclk); #1;
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge rclk);
            e = exp_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL reset step %0d: got %b, expected %b", i, outs, e);
            end
        end
    endtask

    task automatic test_priority();
        logic [10:0] stim [0:8];
        logic [9:0]  expv [0:8];
        logic [9:0]  e;
        stim = '{11'b0_100_0_10_00_00, 11'b0_000_0_00_00_00, 11'b0_000_1_00_10_00,
                 11'b0_000_0_00_00_00, 11'b0_000_0_10_00_00, 11'b0_000_0_00_00_00,
                 11'b0_110_1_00_00_00, 11'b0_000_0_00_00_00, 11'b0_000_0_00_00_00};
        expv = '{10'b0001_1_0_00_0_0, 10'b0000_0_0_00_0_1, 10'b0010_1_0_00_0_0,
                 10'b0000_0_0_00_0_1, 10'b0100_0_1_00_0_0, 10'b0000_0_0_00_0_0,
                 10'b0001_0_1_00_0_0, 10'b0000_0_0_00_0_1, 10'b0000_0_0_00_0_0};
        idle_cycle();
        for (int i = 0; i < 9; i++) begin
            @(posedge rclk); #1;
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge rclk);
            e = exp_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL priority step %0d: got %b, expected %b", i, outs, e);
            end
        end
    endtask

    task automatic test_lock();
        logic [10:0] stim [0:6];
        logic [9:0]  expv [0:6];
        logic [9:0]  e;
        stim = '{11'b0_101_1_00_00_00, 11'b0_101_1_00_00_00, 11'b0_101_1_00_00_00,
                 11'b0_101_1_00_00_00, 11'b0_000_1_00_00_00, 11'b0_000_1_00_00_00,
                 11'b0_000_0_00_00_00};
        expv = '{10'b0001_1_0_00_0_0, 10'b0001_1_0_00_1_1, 10'b0001_1_0_00_1_1,
                 10'b0001_1_0_00_1_1, 10'b0000_0_0_00_1_1, 10'b0010_1_0_00_0_1,
                 10'b0000_0_0_00_0_0};
        idle_cycle();
        for (int i = 0; i < 7; i++) begin
            @(posedge rclk); #1;
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge rclk);
            e = exp_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL lock step %0d: got %b, expected %b", i, outs, e);
            end
        end
    endtask

    task automatic test_turnaround();
        logic [10:0] stim [0:9];
        logic [9:0]  expv [0:9];
        logic [9:0]  e;
        stim = '{11'b0_000_0_10_00_00, 11'b0_000_0_00_10_00, 11'b0_000_0_00_10_00,
                 11'b0_110_0_00_00_00, 11'b0_100_0_00_00_00, 11'b0_110_0_00_00_00,
                 11'b0_000_0_10_00_00, 11'b0_000_1_00_00_00, 11'b0_000_1_00_00_00,
                 11'b0_000_0_00_00_00};
        expv = '{10'b0100_0_1_00_0_0, 10'b0000_0_0_00_0_0, 10'b1000_1_0_00_0_1,
                 10'b0001_0_1_00_0_0, 10'b0001_1_0_00_0_0, 10'b0001_0_1_00_0_0,
                 10'b0100_0_1_00_0_0, 10'b0000_0_0_00_0_0, 10'b0010_1_0_00_0_1,
                 10'b0000_0_0_00_0_0};
        idle_cycle();
        for (int i = 0; i < 10; i++) begin
            @(posedge rclk); #1;
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge rclk);
            e = exp_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL turnaround step %0d: got %b, expected %b", i, outs, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [10:0] stim [0:7];
        logic [9:0]  expv [0:7];
        logic [9:0]  e;
        stim = '{11'b0_000_0_11_00_00, 11'b0_000_0_11_00_00, 11'b0_000_0_11_00_10,
                 11'b0_000_0_10_00_00, 11'b0_000_0_00_00_00, 11'b0_000_0_00_10_01,
                 11'b0_000_0_00_10_00, 11'b0_000_0_00_00_00};
        expv = '{10'b0100_0_1_00_0_0, 10'b0100_0_1_10_1_0, 10'b0000_0_0_10_1_0,
                 10'b0100_0_1_10_0_1, 10'b0000_0_0_10_0_0, 10'b0000_0_0_10_0_0,
                 10'b1000_1_0_10_0_1, 10'b0000_0_0_10_0_0};
        idle_cycle();
        for (int i = 0; i < 8; i++) begin
            @(posedge rclk); #1;
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge rclk);
            e = exp_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL abort step %0d: got %b, expected %b", i, outs, e);
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [10:0] stim [0:5];
        logic [9:0]  expv [0:5];
        logic [9:0]  e;
        stim = '{11'b0_000_0_00_11_00, 11'b0_000_0_00_11_00, 11'b1_000_0_00_11_00,
                 11'b0_000_0_00_00_00, 11'b0_001_0_01_01_00, 11'b0_000_0_00_00_00};
        expv = '{10'b1000_1_0_10_0_0, 10'b1000_1_0_11_1_0, 10'b0000_0_0_11_1_0,
                 10'b0000_0_0_00_0_0, 10'b0000_0_0_00_0_0, 10'b0000_0_0_00_0_0};
        idle_cycle();
        for (int i = 0; i < 6; i++) begin
            @(posedge rclk); #1;
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge rclk);
            e = exp_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL reset_mid_lock step %0d: got %b, expected %b", i, outs, e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [9:0] e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(posedge rclk); #1;
            apply(11'b0_000_0_10_10_00);
`ifdef SPU_MAMEM_ARB_RR_EN
            case (i % 3)
                0:       eg = 4'b0100;
                1:       eg = 4'b0000;
                default: eg = 4'b1000;
            endcase
`else
            eg = 4'b0100;
`endif
            exp_q.push_back({eg, eg[3], eg[2], 2'b00, 1'b0, (i != 0)});
            @(negedge rclk);
            e = exp_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL round_robin step %0d: got %b, expected %b", i, outs, e);
            end
        end
        idle_cycle();
    endtask

    task automatic test_random();
        logic [10:0] v;
        for (int i = 0; i < 10000; i++) begin
            @(posedge rclk); #1;
            v = 11'($urandom) & 11'b0_111_1_11_11_00;
            if ($urandom_range(0, 15) == 0) v[1] = 1'b1;
            if ($urandom_range(0, 15) == 0) v[0] = 1'b1;
            apply(v);
            @(negedge rclk);
            checks++;
            if (rd_en && wr_en) begin
                errors++;
                $display("[TB] FAIL random_rdwr cycle %0d: rd_en=%b wr_en=%b, required not both high", i, rd_en, wr_en);
            end
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("[TB] FAIL random_onehot cycle %0d: gnt=%b, required one-hot or zero", i, gnt);
            end
            checks++;
            if ((rd_en | wr_en) !== (|gnt)) begin
                errors++;
                $display("[TB] FAIL random_enable cycle %0d: rd_en|wr_en=%b, required %b", i, rd_en | wr_en, |gnt);
            end
        end
        idle_cycle();
    endtask

    // Watchdog against a stalled run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        se = 1'b0;
        apply(11'b1_000_0_00_00_00);
        repeat (2) @(posedge rclk);
        test_reset();
        test_priority();
        test_lock();
        test_turnaround();
        test_abort();
        test_reset_mid_lock();
        test_round_robin();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
